// File: rtl/pwm_window_sequencer_if.sv
// Config write port of pwm_window_sequencer.
// A write is taken on a rising edge when cfg_we and cfg_ready are both high.
interface pwm_window_sequencer_if #(
    parameter int unsigned N_CH = 4
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            cfg_we;
    logic [CH_W-1:0] cfg_ch;
    logic [5:0]      cfg_duty;
    logic [5:0]      cfg_lo;
    logic [5:0]      cfg_hi;
    logic            cfg_ready;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_duty,
        output cfg_lo,
        output cfg_hi,
        input  cfg_ready
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_duty,
        input  cfg_lo,
        input  cfg_hi,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_window_sequencer.sv
// Multi-channel windowed PWM sequencer.
// The 64-clock period counter, the PRESCALE-period prescaler and the 6-bit window index are
// shared by all channels. Each channel owns a duty cycle and an index window (lo, hi).
// Config writes land in shadow registers and are committed to the active set glitch-free:
// immediately while stopped or paused, and only at the index wrap while running.
module pwm_window_sequencer #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned PRESCALE = 13
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic                  stop_req,
    pwm_window_sequencer_if.slave cfg,
    output logic [N_CH-1:0]       pulse,
    output logic [5:0]            index,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [5:0]      r_count;
    logic [5:0]      w_count_next;
    logic [PS_W-1:0] r_presc;
    logic [PS_W-1:0] w_presc_next;
    logic [5:0]      r_index;
    logic [5:0]      w_index_next;
    logic            r_pause_pend;
    logic            w_pause_pend_next;
    logic            w_wrap;

    logic [N_CH-1:0][5:0] r_sh_duty;
    logic [N_CH-1:0][5:0] r_sh_lo;
    logic [N_CH-1:0][5:0] r_sh_hi;
    logic [N_CH-1:0]      r_dirty;
    logic [N_CH-1:0][5:0] r_act_duty;
    logic [N_CH-1:0][5:0] r_act_lo;
    logic [N_CH-1:0][5:0] r_act_hi;

    logic                 w_commit;
    logic                 w_write;
    logic [N_CH-1:0][5:0] w_duty_eff;
    logic [N_CH-1:0]      w_pulse_next;
    logic [N_CH-1:0]      r_pulse;
    logic                 r_frame_done;

    // Sequencer state and shared counters.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_count      <= '0;
            r_presc      <= '0;
            r_index      <= '0;
            r_pause_pend <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_presc      <= w_presc_next;
            r_index      <= w_index_next;
            r_pause_pend <= w_pause_pend_next;
        end
    end

    // Next-state and counter advance; a requested pause lets the current period finish.
    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_presc_next      = r_presc;
        w_index_next      = r_index;
        w_pause_pend_next = r_pause_pend;
        w_wrap            = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_count_next      = '0;
                w_presc_next      = '0;
                w_index_next      = '0;
                w_pause_pend_next = 1'b0;
                if (start) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_count_next = r_count + 6'd1;
                if (stop_req) begin
                    w_pause_pend_next = 1'b1;
                end
                if (r_count == 6'd63) begin
                    if (r_presc == PS_LAST) begin
                        w_presc_next = '0;
                        w_index_next = r_index + 6'd1;
                        w_wrap       = (r_index == 6'd63);
                    end else begin
                        w_presc_next = r_presc + 1'b1;
                    end
                    if (r_pause_pend) begin
                        w_state_next      = StPause;
                        w_pause_pend_next = 1'b0;
                    end
                end
            end
            StPause: begin
                if (stop_req) begin
                    w_state_next = StIdle;
                    w_count_next = '0;
                    w_presc_next = '0;
                    w_index_next = '0;
                end else if (start) begin
                    w_state_next = StRun;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // A commit edge blocks the write port so shadow and dirty never race the copy.
    assign w_commit      = (|r_dirty) && ((r_state != StRun) || w_wrap);
    assign w_write       = cfg.cfg_we && !w_commit;
    assign cfg.cfg_ready = !w_commit;

    // Shadow capture on accepted writes, shadow-to-active copy on commit edges.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_sh_duty  <= '0;
            r_sh_lo    <= '0;
            r_sh_hi    <= '0;
            r_dirty    <= '0;
            r_act_duty <= '0;
            r_act_lo   <= '0;
            r_act_hi   <= '0;
        end else begin
            if (w_commit) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (r_dirty[c]) begin
                        r_act_duty[c] <= r_sh_duty[c];
                        r_act_lo[c]   <= r_sh_lo[c];
                        r_act_hi[c]   <= r_sh_hi[c];
                    end
                end
                r_dirty <= '0;
            end
            if (w_write) begin
                r_sh_duty[cfg.cfg_ch] <= cfg.cfg_duty;
                r_sh_lo[cfg.cfg_ch]   <= cfg.cfg_lo;
                r_sh_hi[cfg.cfg_ch]   <= cfg.cfg_hi;
                r_dirty[cfg.cfg_ch]   <= 1'b1;
            end
        end
    end

    // Per-channel compare: duty only counts while the index is strictly inside the window.
    always_comb begin
        w_duty_eff   = '0;
        w_pulse_next = '0;
        for (int c = 0; c < N_CH; c++) begin
            if ((r_act_lo[c] < r_index) && (r_index < r_act_hi[c])) begin
                w_duty_eff[c] = r_act_duty[c];
            end
            w_pulse_next[c] = enable && (r_state == StRun) && (r_count < w_duty_eff[c]);
        end
    end

    // Registered pulse and frame outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_pulse      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_pulse      <= w_pulse_next;
            r_frame_done <= w_wrap;
        end
    end

    assign pulse      = r_pulse;
    assign frame_done = r_frame_done;
    assign index      = r_index;
    assign busy       = (r_state != StIdle);
endmodule

// File: tb/tb_pwm_window_sequencer.sv
// Directed bench for pwm_window_sequencer.
// k counts rising edges since the last start; outputs are read 1 time unit after each edge.
module tb_pwm_window_sequencer;
    logic       sysclk = 1'b0;
    logic       reset;
    logic       enable;
    logic       start;
    logic       stop_req;
    logic [3:0] pulse;
    logic [5:0] index;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;
    int fd_cnt   = 0;
    int hi_cnt[4];

    pwm_window_sequencer_if #(.N_CH(4)) cfg_bus ();

    pwm_window_sequencer #(
        .N_CH     (4),
        .PRESCALE (13)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .stop_req   (stop_req),
        .cfg        (cfg_bus),
        .pulse      (pulse),
        .index      (index),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 sysclk = ~sysclk;

    task automatic step();
        @(posedge sysclk);
        #1;
        k++;
        fd_cnt += int'(frame_done);
        for (int c = 0; c < 4; c++) hi_cnt[c] += int'(pulse[c]);
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic clear_counts();
        fd_cnt = 0;
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [5:0] d, input logic [5:0] lo,
                            input logic [5:0] hi);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_ch   = ch;
        cfg_bus.cfg_duty = d;
        cfg_bus.cfg_lo   = lo;
        cfg_bus.cfg_hi   = hi;
        step();
        cfg_bus.cfg_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if (pulse !== 4'h0) begin
            n_errors++; $display("FAIL reset_pulse: got %h want 0", pulse);
        end
        n_checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_errors++; $display("FAIL reset_busy_fd: got busy=%b fd=%b want 0 0", busy, frame_done);
        end
        n_checks++;
        if (cfg_bus.cfg_ready !== 1'b1 || index !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_ready_index: got rdy=%b idx=%0d want 1 0", cfg_bus.cfg_ready, index);
        end
    endtask

    task automatic test_idle_commit();
        do_write(2'd0, 6'd63, 6'd15, 6'd48);
        n_checks++;
        if (cfg_bus.cfg_ready !== 1'b0) begin
            n_errors++; $display("FAIL idle_commit_ready_low: got %b want 0", cfg_bus.cfg_ready);
        end
        step();
        n_checks++;
        if (cfg_bus.cfg_ready !== 1'b1) begin
            n_errors++; $display("FAIL idle_commit_ready_back: got %b want 1", cfg_bus.cfg_ready);
        end
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++; $display("FAIL idle_stop_ignored: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_frame();
        enable = 1'b1;
        pulse_start();
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++; $display("FAIL run_busy: got %b want 1", busy);
        end
        run_to(12490);
        n_checks++;
        if (index !== 6'd15 || pulse[0] !== 1'b0) begin
            n_errors++; $display("FAIL win_idx15: got idx=%0d p0=%b want 15 0", index, pulse[0]);
        end
        run_to(13313);
        n_checks++;
        if (pulse[0] !== 1'b1) begin
            n_errors++; $display("FAIL win_idx16_cnt0: got %b want 1", pulse[0]);
        end
        run_to(13376);
        n_checks++;
        if (pulse[0] !== 1'b0) begin
            n_errors++; $display("FAIL win_idx16_cnt63: got %b want 0", pulse[0]);
        end
        run_to(16640);
        clear_counts();
        run_to(16704);
        n_checks++;
        if (hi_cnt[0] != 63) begin
            n_errors++; $display("FAIL duty63_count: got %0d want 63", hi_cnt[0]);
        end
        run_to(20000);
        n_checks++;
        if (cfg_bus.cfg_ready !== 1'b1) begin
            n_errors++; $display("FAIL run_ready_before_write: got %b want 1", cfg_bus.cfg_ready);
        end
        do_write(2'd1, 6'd32, 6'd0, 6'd63);
        clear_counts();
        n_checks++;
        if (cfg_bus.cfg_ready !== 1'b1) begin
            n_errors++; $display("FAIL run_ready_after_write: got %b want 1", cfg_bus.cfg_ready);
        end
        run_to(39110);
        n_checks++;
        if (pulse[0] !== 1'b1) begin
            n_errors++; $display("FAIL win_idx47: got %b want 1", pulse[0]);
        end
        run_to(39942);
        n_checks++;
        if (pulse[0] !== 1'b0) begin
            n_errors++; $display("FAIL win_idx48: got %b want 0", pulse[0]);
        end
        run_to(53246);
        n_checks++;
        if (hi_cnt[1] != 0 || fd_cnt != 0 || cfg_bus.cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midframe_hold: got hi1=%0d fd=%0d rdy=%b want 0 0 1",
                     hi_cnt[1], fd_cnt, cfg_bus.cfg_ready);
        end
        run_to(53247);
        n_checks++;
        if (cfg_bus.cfg_ready !== 1'b0 || index !== 6'd63 || frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL pre_wrap: got rdy=%b idx=%0d fd=%b want 0 63 0",
                     cfg_bus.cfg_ready, index, frame_done);
        end
        run_to(53248);
        n_checks++;
        if (cfg_bus.cfg_ready !== 1'b1 || index !== 6'd0 || frame_done !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap: got rdy=%b idx=%0d fd=%b want 1 0 1",
                     cfg_bus.cfg_ready, index, frame_done);
        end
        run_to(53249);
        n_checks++;
        if (frame_done !== 1'b0 || fd_cnt != 1) begin
            n_errors++; $display("FAIL fd_single: got fd=%b cnt=%0d want 0 1", frame_done, fd_cnt);
        end
        run_to(54080);
        clear_counts();
        run_to(54144);
        n_checks++;
        if (hi_cnt[1] != 32) begin
            n_errors++; $display("FAIL ch1_duty32: got %0d want 32", hi_cnt[1]);
        end
    endtask

    task automatic test_pause();
        run_to(54154);
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        run_to(54208);
        clear_counts();
        run_to(54308);
        n_checks++;
        if ((hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]) != 0 || index !== 6'd1
            || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL pause_frozen: got highs=%0d idx=%0d busy=%b want 0 1 1",
                     hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], index, busy);
        end
        pulse_start();
        run_to(1);
        n_checks++;
        if (pulse !== 4'b0010) begin
            n_errors++; $display("FAIL resume_cnt0: got %b want 0010", pulse);
        end
        run_to(32);
        n_checks++;
        if (pulse[1] !== 1'b1) begin
            n_errors++; $display("FAIL resume_cnt31: got %b want 1", pulse[1]);
        end
        run_to(33);
        n_checks++;
        if (pulse[1] !== 1'b0) begin
            n_errors++; $display("FAIL resume_cnt32: got %b want 0", pulse[1]);
        end
    endtask

    task automatic test_start_stop_together();
        start    = 1'b1;
        stop_req = 1'b1;
        step();
        start    = 1'b0;
        stop_req = 1'b0;
        run_to(66);
        n_checks++;
        if (pulse[1] !== 1'b0 || busy !== 1'b1) begin
            n_errors++; $display("FAIL start_stop_run: got p1=%b busy=%b want 0 1", pulse[1], busy);
        end
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || index !== 6'd0) begin
            n_errors++; $display("FAIL pause_to_idle: got busy=%b idx=%0d want 0 0", busy, index);
        end
    endtask

    task automatic test_enable();
        pulse_start();
        run_to(833);
        n_checks++;
        if (pulse !== 4'b0010) begin
            n_errors++; $display("FAIL en_before: got %b want 0010", pulse);
        end
        enable = 1'b0;
        run_to(834);
        n_checks++;
        if (pulse !== 4'b0000) begin
            n_errors++; $display("FAIL en_off_first: got %b want 0000", pulse);
        end
        run_to(840);
        n_checks++;
        if (pulse !== 4'b0000) begin
            n_errors++; $display("FAIL en_off_held: got %b want 0000", pulse);
        end
        enable = 1'b1;
        run_to(841);
        n_checks++;
        if (pulse !== 4'b0010) begin
            n_errors++; $display("FAIL en_back_cnt8: got %b want 0010", pulse);
        end
        run_to(864);
        n_checks++;
        if (pulse[1] !== 1'b1) begin
            n_errors++; $display("FAIL en_cnt31: got %b want 1", pulse[1]);
        end
        run_to(866);
        n_checks++;
        if (pulse[1] !== 1'b0 || index !== 6'd1) begin
            n_errors++; $display("FAIL en_cnt33: got p1=%b idx=%0d want 0 1", pulse[1], index);
        end
    endtask

    task automatic test_reset_midrun();
        do_write(2'd3, 6'd10, 6'd0, 6'd63);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (pulse !== 4'h0 || busy !== 1'b0 || index !== 6'd0 || frame_done !== 1'b0
            || cfg_bus.cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midrun_reset: got p=%b busy=%b idx=%0d fd=%b rdy=%b want 0 0 0 0 1",
                     pulse, busy, index, frame_done, cfg_bus.cfg_ready);
        end
        step();
        pulse_start();
        clear_counts();
        run_to(900);
        n_checks++;
        if ((hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]) != 0 || index !== 6'd1) begin
            n_errors++;
            $display("FAIL cfg_cleared: got highs=%0d idx=%0d want 0 1",
                     hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], index);
        end
    endtask

    initial begin
        reset            = 1'b1;
        enable           = 1'b0;
        start            = 1'b0;
        stop_req         = 1'b0;
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.cfg_ch   = '0;
        cfg_bus.cfg_duty = '0;
        cfg_bus.cfg_lo   = '0;
        cfg_bus.cfg_hi   = '0;
        clear_counts();
        test_reset();
        test_idle_commit();
        test_frame();
        test_pause();
        test_start_stop_together();
        test_enable();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pwm_window_sequencer.md
Name: pwm_window_sequencer

Overview:
- Multi-channel controller for the square-wave PWM generators used on the board.
- Owns a shared 6-bit PWM period counter, a 13-period prescaler and a 6-bit window index.
- Per channel: duty cycle and index on-window, set through a small config write port.
- Commits config glitch-free at frame boundaries; run/pause/stop sequencing via a 3-state FSM.

Parameters:
- N_CH, 4, number of PWM channels (cfg_ch width = 2 at the default).
- PRESCALE, 13, PWM periods per index step (index advances after periods 0..PRESCALE-1).

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  output gate switch; 0 forces every pulse output low, counters unaffected.
- start  in  1  single-cycle run/resume request.
- stop_req  in  1  single-cycle pause/stop request.
- cfg_we  in  1  config write strobe; accepted only when cfg_ready=1.
- cfg_ch  in  2  target channel.
- cfg_duty  in  6  high time in clocks per 64-clock period.
- cfg_lo  in  6  window lower bound (exclusive).
- cfg_hi  in  6  window upper bound (exclusive).
- cfg_ready  out  1  config port can accept a write.
- pulse  out  N_CH  per-channel PWM outputs.
- index  out  6  current window index.
- busy  out  1  high in RUN or PAUSE.
- frame_done  out  1  one-cycle pulse when index wraps 63->0.

Behaviour:
- Reset: state=IDLE; count, prescaler, index = 0; all shadow and active config = 0.
- Reset outputs: pulse=0, frame_done=0, busy=0, cfg_ready=1.
- Reset mid-run: same result on the next edge; pending shadow writes are discarded.
- FSM IDLE: counters held at 0; pulse=0.
  - start -> RUN.
  - stop_req ignored.
- FSM RUN: count increments by 1 every clock, wrapping 63->0.
  - At count==63: prescaler increments.
  - If prescaler==PRESCALE-1 at count==63: prescaler->0 and index increments.
  - Index wraps 63->0; frame_done pulses for 1 cycle coincident with the wrap edge.
  - stop_req sets a pending-pause flag.
  - On the next count==63 edge with the flag set, go to PAUSE and clear the flag.
  - That period completes in full.
- FSM PAUSE: count, prescaler and index frozen; pulse=0.
  - start -> RUN, resuming from the frozen count.
  - stop_req -> IDLE; counters cleared.
- Simultaneous start and stop_req:
  - stop_req wins in RUN and PAUSE.
  - start wins in IDLE, because stop_req is ignored there.
- Pulse equation: pulse[c] = enable & RUN & (count < duty_eff[c]).
  - duty_eff[c] = duty[c] when lo[c] < index < hi[c], strict unsigned compare; otherwise 0.
  - duty 0 gives never-high; duty 63 gives 63/64 high.
  - lo >= hi-1 gives an empty window: channel always low.
- Outputs are registered: pulse reflects the count/index of the previous cycle, i.e. 1-cycle latency from the count value.
- Config handshake: a write occurs when cfg_we & cfg_ready on an edge.
  - The write stores duty/lo/hi into the channel's shadow registers.
  - A later write to the same channel overwrites its shadow.
- Commit in IDLE or PAUSE: shadow copies to active on the edge after the write.
- Commit in RUN: shadow copies to active on the index-wrap edge (frame_done edge). Active config never changes mid-frame.
- cfg_ready is 0 only on the single cycle of a commit edge. A cfg_we on that cycle is not accepted and must be held by the writer.
- Commits happen only for channels with a dirty flag; the flag clears on commit.

Test Plan:
- Reset, write ch0 duty=63 lo=15 hi=48 in IDLE, start, enable=1 -> pulse[0] low while index<=15.
  - High 63 of 64 clocks for index 16..47; low again at index 48.
  - Index steps every 13*64=832 clocks.
- Run 64 index steps -> frame_done single-cycle pulse exactly when index goes 63->0, once per 53248 clocks.
- RUN, write ch1 duty=32 lo=0 hi=63 mid-frame -> pulse[1] unchanged until the wrap edge; cfg_ready low for exactly that cycle.
  - Afterwards pulse[1] is high for 32 of 64 clocks.
- stop_req at count=10 -> PAUSE entered after count=63; pulse=0, index frozen.
  - start -> resumes from count=0 of the next period.
  - stop_req in PAUSE -> IDLE, index=0, busy=0.
- enable toggled 1->0->1 during RUN -> pulse forced 0 while enable=0; index and count advance uninterrupted.
- start and stop_req asserted together in RUN -> pending pause set, no restart.
- Reset asserted mid-frame -> all outputs 0 next cycle, active config cleared.
